// File: rtl/func_request_encoder_if.sv
// Request-side bus between the user panels and the function encoder:
// raw buttons and selection switches in, active function codes and priority out.
interface func_request_encoder_if;
    logic       i_btn_ie1;
    logic       i_btn_ie2;
    logic [2:0] i_sel_ie1;
    logic [2:0] i_sel_ie2;
    logic [2:0] o_func_ie1;
    logic [2:0] o_func_ie2;
    logic       o_priority;

    modport master (
        output i_btn_ie1, i_btn_ie2, i_sel_ie1, i_sel_ie2,
        input  o_func_ie1, o_func_ie2, o_priority
    );
    modport slave (
        input  i_btn_ie1, i_btn_ie2, i_sel_ie1, i_sel_ie2,
        output o_func_ie1, o_func_ie2, o_priority
    );
endinterface

// File: rtl/func_request_encoder.sv
// Per-user button debounce + timed function session, plus the shared priority
// arbiter that downstream function decoders use to resolve same-function requests.
module func_req_user #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn,
    input  logic [2:0] i_sel,
    output logic [2:0] o_func,
    output logic       o_start,
    output logic       o_end,
    output logic       o_stay
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        r_state;
    logic [1:0]    r_sync;
    logic          r_db;
    logic          r_db_q;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_func;

    logic w_press, w_legal, w_active, w_cancel, w_load, w_expire;

    assign w_press  = r_db & ~r_db_q;
    assign w_legal  = (i_sel == 3'b001) | (i_sel == 3'b010) | (i_sel == 3'b100);
    assign w_active = (r_state == ACTIVE);
    assign w_cancel = w_active & w_press & ((i_sel == r_func) | (i_sel == 3'b000));
    assign w_load   = w_press & w_legal & ~w_cancel;
    // An illegal press does not shield the expiry on the same edge.
    assign w_expire = w_active & ~w_cancel & ~w_load & (r_timer == '0);

    assign o_start = w_load;
    assign o_end   = w_cancel | w_expire;
    assign o_stay  = w_active & ~o_end;
    assign o_func  = r_func;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_db    <= 1'b0;
            r_db_q  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
            r_timer <= '0;
            r_func  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_db_q <= r_db;
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_db  <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_load) begin
                r_state <= ACTIVE;
                r_func  <= i_sel;
                r_timer <= TMR_LOAD;
            end else if (o_end) begin
                r_state <= IDLE;
                r_func  <= '0;
                r_timer <= '0;
            end else if (w_active) begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end
endmodule

module func_request_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    func_request_encoder_if.slave bus
);
    localparam int NUM_USERS = 2;

    logic [NUM_USERS-1:0]      w_btn;
    logic [NUM_USERS-1:0][2:0] w_sel;
    logic [NUM_USERS-1:0][2:0] w_func;
    logic [NUM_USERS-1:0]      w_start;
    logic [NUM_USERS-1:0]      w_end;
    logic [NUM_USERS-1:0]      w_stay;
    logic                      r_prio;
    logic                      r_tie;

    assign w_btn = {bus.i_btn_ie2, bus.i_btn_ie1};
    assign w_sel = {bus.i_sel_ie2, bus.i_sel_ie1};

    for (genvar u = 0; u < NUM_USERS; u++) begin : g_user
        func_req_user #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES)
        ) u_user (
            .clk    (clk),
            .reset  (reset),
            .i_btn  (w_btn[u]),
            .i_sel  (w_sel[u]),
            .o_func (w_func[u]),
            .o_start(w_start[u]),
            .o_end  (w_end[u]),
            .o_stay (w_stay[u])
        );
    end

    assign bus.o_func_ie1 = w_func[0];
    assign bus.o_func_ie2 = w_func[1];
    assign bus.o_priority = r_prio;

    // 1 = IE1 has precedence; an already-running session outranks a new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= 1'b1;
            r_tie  <= 1'b1;
        end else if (&w_start) begin
            r_prio <= r_tie;
            r_tie  <= ~r_tie;
        end else if (w_start[0]) begin
            r_prio <= ~w_stay[1];
        end else if (w_start[1]) begin
            r_prio <= w_stay[0];
        end else if (w_end[0] & w_stay[1]) begin
            r_prio <= 1'b0;
        end else if (w_end[1] & w_stay[0]) begin
            r_prio <= 1'b1;
        end
    end
endmodule

// File: tb/tb_func_request_encoder.sv
// Directed scenarios plus random button traffic, checked every cycle against
// an event-level model (deadline-based sessions, delay-queue synchronizer).
module tb_func_request_encoder;
    localparam int DB   = 4;
    localparam int HOLD = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    func_request_encoder_if bus ();

    func_request_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc;
    logic [2:0] m_func [2];
    int         m_dead [2];
    bit         m_db   [2];
    int         m_run  [2];
    bit         m_pend [2];
    bit         m_prio, m_tie;
    bit         dq0[$], dq1[$];

    task automatic m_user(input int u, input bit raw, input logic [2:0] sel,
                          output bit st, output bit en, output bit stay);
        bit samp, press, act;
        if (u == 0) begin dq0.push_back(raw); samp = dq0.pop_front(); end
        else        begin dq1.push_back(raw); samp = dq1.pop_front(); end
        press     = m_pend[u];
        m_pend[u] = 0;
        if (samp != m_db[u]) begin
            m_run[u]++;
            if (m_run[u] == DB) begin
                m_db[u]   = samp;
                m_run[u]  = 0;
                m_pend[u] = samp;
            end
        end else m_run[u] = 0;
        st  = 0;
        en  = 0;
        act = (m_func[u] != 3'b000);
        if (press && act && (sel == m_func[u] || sel == 3'b000)) en = 1;
        else if (press && (sel inside {3'b001, 3'b010, 3'b100})) begin
            m_func[u] = sel;
            m_dead[u] = cyc + HOLD;
            st = 1;
        end else if (act && cyc == m_dead[u]) en = 1;
        if (en) m_func[u] = 3'b000;
        stay = act && !en;
    endtask

    task automatic m_step();
        bit s0, e0, k0, s1, e1, k1;
        if (reset) begin
            cyc = 0;
            dq0 = '{1'b0, 1'b0};
            dq1 = '{1'b0, 1'b0};
            for (int u = 0; u < 2; u++) begin
                m_func[u] = 3'b000; m_dead[u] = 0; m_db[u] = 0; m_run[u] = 0; m_pend[u] = 0;
            end
            m_prio = 1;
            m_tie  = 1;
        end else begin
            m_user(0, bus.i_btn_ie1, bus.i_sel_ie1, s0, e0, k0);
            m_user(1, bus.i_btn_ie2, bus.i_sel_ie2, s1, e1, k1);
            if (s0 && s1) begin m_prio = m_tie; m_tie = !m_tie; end
            else if (s0)        m_prio = !k1;
            else if (s1)        m_prio = k0;
            else if (e0 && k1)  m_prio = 0;
            else if (e1 && k0)  m_prio = 1;
            cyc++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("lock_f1", bus.o_func_ie1, m_func[0]);
            chk("lock_f2", bus.o_func_ie2, m_func[1]);
            chk("lock_pr", {2'b00, bus.o_priority}, {2'b00, m_prio});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_in(input int u, input logic b, input logic [2:0] s);
        if (u == 0) begin bus.i_btn_ie1 = b; bus.i_sel_ie1 = s; end
        else        begin bus.i_btn_ie2 = b; bus.i_sel_ie2 = s; end
    endtask

    task automatic press(input int u, input logic [2:0] s);
        set_in(u, 1'b1, s);
        repeat (6) tick();
        set_in(u, 1'b0, s);
        repeat (6) tick();
    endtask

    logic [2:0] sels [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b010, 3'b001};
    int         rem  [2];
    bit         lvl  [2];

    initial begin
        set_in(0, 1'b0, 3'b000);
        set_in(1, 1'b0, 3'b000);
        repeat (3) tick();
        reset  = 1'b0;
        chk_en = 1;
        repeat (5) tick();
        chk("rst_f1", bus.o_func_ie1, 3'b000);
        chk("rst_f2", bus.o_func_ie2, 3'b000);
        chk("rst_pr", {2'b00, bus.o_priority}, 3'b001);

        // single press: visible 6 edges after first sample, lasts HOLD edges
        for (int k = 0; k <= 30; k++) begin
            if (k == 0)  set_in(0, 1'b1, 3'b010);
            if (k == 10) set_in(0, 1'b0, 3'b010);
            if (k == 6)  chk("lat_early", bus.o_func_ie1, 3'b000);
            if (k == 7) begin
                chk("lat_f1", bus.o_func_ie1, 3'b010);
                chk("lat_pr", {2'b00, bus.o_priority}, 3'b001);
            end
            if (k == 22) chk("hold_last", bus.o_func_ie1, 3'b010);
            if (k == 23) chk("hold_exp", bus.o_func_ie1, 3'b000);
            tick();
        end

        // glitch then illegal code on IE2
        set_in(1, 1'b1, 3'b010);
        repeat (3) tick();
        set_in(1, 1'b0, 3'b010);
        repeat (12) tick();
        chk("glitch_f2", bus.o_func_ie2, 3'b000);
        press(1, 3'b011);
        repeat (4) tick();
        chk("illegal_f2", bus.o_func_ie2, 3'b000);

        // older session keeps precedence
        for (int k = 0; k <= 40; k++) begin
            if (k == 0)  set_in(1, 1'b1, 3'b010);
            if (k == 5)  set_in(0, 1'b1, 3'b010);
            if (k == 8)  set_in(1, 1'b0, 3'b010);
            if (k == 13) set_in(0, 1'b0, 3'b010);
            if (k == 13) begin
                chk("old_f1", bus.o_func_ie1, 3'b010);
                chk("old_f2", bus.o_func_ie2, 3'b010);
                chk("old_pr", {2'b00, bus.o_priority}, 3'b000);
            end
            if (k == 22) chk("old_pr_late", {2'b00, bus.o_priority}, 3'b000);
            if (k == 23) begin
                chk("old_f2_exp", bus.o_func_ie2, 3'b000);
                chk("old_pr_hand", {2'b00, bus.o_priority}, 3'b001);
            end
            if (k == 27) chk("old_f1_last", bus.o_func_ie1, 3'b010);
            if (k == 28) chk("old_f1_exp", bus.o_func_ie1, 3'b000);
            tick();
        end

        // simultaneous starts alternate the tie-break
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k <= 40; k++) begin
                if (k == 0) begin set_in(0, 1'b1, 3'b001); set_in(1, 1'b1, 3'b001); end
                if (k == 8) begin
                    set_in(0, 1'b0, 3'b001);
                    set_in(1, 1'b0, 3'b001);
                    chk("sim_f1", bus.o_func_ie1, 3'b001);
                    chk("sim_f2", bus.o_func_ie2, 3'b001);
                    chk("sim_pr", {2'b00, bus.o_priority}, (rep == 0) ? 3'b001 : 3'b000);
                end
                tick();
            end
        end

        // cancel, restart, reset mid-session
        press(0, 3'b001);
        chk("can_on", bus.o_func_ie1, 3'b001);
        press(0, 3'b001);
        chk("can_off", bus.o_func_ie1, 3'b000);
        press(0, 3'b100);
        chk("rs_first", bus.o_func_ie1, 3'b100);
        press(0, 3'b010);
        chk("rs_new", bus.o_func_ie1, 3'b010);
        repeat (10) tick();
        chk("rs_full", bus.o_func_ie1, 3'b010);
        tick();
        chk("rs_exp", bus.o_func_ie1, 3'b000);
        press(0, 3'b001);
        chk("mid_on", bus.o_func_ie1, 3'b001);
        reset = 1'b1;
        tick();
        chk("mid_rst_f1", bus.o_func_ie1, 3'b000);
        chk("mid_rst_pr", {2'b00, bus.o_priority}, 3'b001);
        reset = 1'b0;
        repeat (10) tick();

        // random traffic, rare resets
        for (int t = 0; t < 3000; t++) begin
            for (int u = 0; u < 2; u++) begin
                if (rem[u] == 0) begin
                    lvl[u] = !lvl[u];
                    rem[u] = $urandom_range(1, 14);
                    set_in(u, lvl[u], sels[$urandom_range(0, 7)]);
                end
                rem[u]--;
            end
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/func_request_encoder.md
# func_request_encoder

Request-side encoder for the two user interfaces (IE1, IE2). It debounces each user's request button and latches the 3-bit function selection from that user's switches. Each latched function is presented as a timed session on `func_ie1`/`func_ie2`. The block also arbitrates the `priority` bit that downstream per-function decoders use when both users request the same function. It drives the function decoders, including the function-2 display/mux decoder, and is the only source of their `func_ie*` and `priority` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required before a button level change is accepted (≥1).
- `HOLD_CYCLES`, 16: session length in cycles for a latched function (≥2).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `btn_ie1` input 1: raw, asynchronous request button for IE1, active-high.
- `btn_ie2` input 1: raw, asynchronous request button for IE2, active-high.
- `sel_ie1` input 3: IE1 function selection switches, sampled on a press event.
- `sel_ie2` input 3: IE2 function selection switches, sampled on a press event.
- `func_ie1` output 3: IE1 active function code. 000 means idle.
- `func_ie2` output 3: IE2 active function code. 000 means idle.
- `priority` output 1: arbitration result. 1 means IE1 has precedence; 0 means IE2 has precedence.

## Operation
- **Legal codes:** 001 (function 1), 010 (function 2), 100 (function 3). Any other `sel` value at a press is illegal, except 000 as noted below.
- **Input path, per user:**
  - 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synced level differs from the debounced level and clears otherwise.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A press event is a single-cycle pulse on a debounced 0→1 transition. Release generates no event.
- **Session FSM, per user:** states IDLE and ACTIVE.
  - IDLE + press with a legal `sel`: latch `sel` into `func_ieN`, load the timer, go to ACTIVE (start event).
  - IDLE + press with 000 or an illegal `sel`: ignored.
  - ACTIVE + press with the same code, or with 000: cancel. `func_ieN` becomes 000, go to IDLE (end event).
  - ACTIVE + press with a different legal code: latch the new code and reload the timer (restart; counts as a start event).
  - ACTIVE + press with an illegal code: ignored; the timer keeps running.
  - ACTIVE + timer expiry: `func_ieN` becomes 000, go to IDLE (end event).
  - `func_ieN` holds a given code for exactly `HOLD_CYCLES` cycles unless cancelled or restarted.
- **Priority arbitration.** Evaluated on the same edge as the session updates. Rules in precedence order:
  - Both users start on the same edge: `priority` takes the value of the `tie` bit, then `tie` inverts.
  - Exactly one user starts and the other is IDLE or ending on this edge: `priority` points to the starter.
  - Exactly one user starts and the other stays ACTIVE: `priority` points to the other user (older session keeps precedence).
  - One user ends and the other stays ACTIVE: `priority` points to the remaining user.
  - Otherwise `priority` holds.
- **Reset values:** `func_ie1` = `func_ie2` = 000, both FSMs IDLE, timers 0, synchronizers 0, debounced levels 0, `priority` = 1, `tie` = 1.
- **Reset mid-session:** all sessions end immediately with no trailing outputs. A button still held at reset release produces a press only after the full debounce latency.

## Timing
- **Press latency:** the raw button is first sampled high at edge E0. The debounced level rises at edge E0+1+`DEBOUNCE_CYCLES`, and `func_ieN`/`priority` update at E0+2+`DEBOUNCE_CYCLES`. That is 6 edges with default parameters.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` synced cycles produces no event.
- **Expiry:** for a start at edge S, `func_ieN` returns to 000 at edge S+`HOLD_CYCLES`, and `priority` updates on that same edge.
- **Independence:** both users' paths run in parallel with no cross-coupling except `priority`. Outputs are registered and glitch-free.

## Test plan
- **Reset defaults:** hold `reset` 3 cycles, then release → `func_ie1` = `func_ie2` = 000 and `priority` = 1, held while no button is pressed.
- **Single press and expiry:** `sel_ie1` = 010, `btn_ie1` high for 10 cycles → `func_ie1` = 010 and `priority` = 1 at E0+6, return to 000 exactly 16 cycles later.
- **Glitch and illegal code:** a 3-cycle `btn_ie2` pulse → no change. A valid press with `sel_ie2` = 011 → `func_ie2` stays 000.
- **Older session wins:** IE2 starts 010, then 5 cycles later IE1 starts 010 → `priority` = 0 throughout overlap. When IE2 expires, `priority` becomes 1 on the same edge.
- **Simultaneous starts:** both buttons rise together, twice (with full expiry between) → first overlap `priority` = 1, second overlap `priority` = 0.
- **Cancel, restart, and reset mid-session:**
  - IE1 active 001, press with 001 → `func_ie1` = 000.
  - New press with 100, then press with 010 at mid-hold → code becomes 010 and the full 16 cycles restart.
  - Assert `reset` mid-session → outputs at reset values on the next edge.
